// File: rtl/xc_malu_pkg.sv
// xc_malu_pkg
//   Shared definitions for the multi-cycle ALU issue logic:
//   - OP_* request operation codes (0..13); codes 14/15 are illegal
//   - OP_IS_LONG mask marking ops whose result is the full 64-bit word
//   - state_t sequencer states
//   - op_is_long() helper
package xc_malu_pkg;

  localparam logic [3:0] OP_DIV    = 4'd0;
  localparam logic [3:0] OP_DIVU   = 4'd1;
  localparam logic [3:0] OP_REM    = 4'd2;
  localparam logic [3:0] OP_REMU   = 4'd3;
  localparam logic [3:0] OP_MUL    = 4'd4;
  localparam logic [3:0] OP_MULU   = 4'd5;
  localparam logic [3:0] OP_MULSU  = 4'd6;
  localparam logic [3:0] OP_CLMUL  = 4'd7;
  localparam logic [3:0] OP_PMUL   = 4'd8;
  localparam logic [3:0] OP_PCLMUL = 4'd9;
  localparam logic [3:0] OP_MADD   = 4'd10;
  localparam logic [3:0] OP_MSUB   = 4'd11;
  localparam logic [3:0] OP_MACC   = 4'd12;
  localparam logic [3:0] OP_MMUL   = 4'd13;

  localparam int unsigned NUM_UOPS = 14;

  // One bit per op code: madd, msub, macc, mmul return all 64 bits.
  localparam logic [15:0] OP_IS_LONG = 16'b0011_1100_0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic op_is_long(input logic [3:0] op);
    return OP_IS_LONG[op];
  endfunction

endpackage

// File: rtl/xc_malu_issue_dec.sv
// xc_malu_issue_dec
//   Combinational decode of an operation code into the ALU's one-hot uop lines.
//   Ports:
//     op       in   4   operation code (OP_*)
//     uop      out  14  one-hot uop, bit i set when op == i; all zero for illegal ops
//     is_long  out  1   op returns the full 64-bit result
import xc_malu_pkg::*;

module xc_malu_issue_dec (
  input  logic [3:0]          op,
  output logic [NUM_UOPS-1:0] uop,
  output logic                is_long
);

  always_comb begin
    uop = '0;
    for (int unsigned i = 0; i < NUM_UOPS; i++) begin
      uop[i] = (op == 4'(i));
    end
    is_long = op_is_long(op);
  end

endmodule

// File: rtl/xc_malu_issue.sv
// xc_malu_issue
//   Sequencer between the pipeline and the multi-cycle ALU (xc_malu). Accepts one
//   request, registers operands, drives uop/pack-width/valid to the ALU, waits for
//   malu_ready, captures and selects the result, pulses malu_flush to return the
//   ALU to its init state and presents a response until consumed.
//   Parameters:
//     TIMEOUT  cycles in RUN before the request is abandoned with rsp_err=1
//     CW       watchdog counter width; must hold TIMEOUT-1
//   Ports:
//     clock, resetn              clock, asynchronous active-low reset
//     req_valid/req_ready        request handshake
//     req_op/hi/pw/rs1-3/rd      request op code, high-half select, one-hot pack
//                                width {pw_2,pw_4,pw_8,pw_16,pw_32}, operands, tag
//     cancel                     pipeline kill, abandons any in-flight request
//     rsp_valid/rsp_ready        response handshake
//     rsp_data/rsp_rd/rsp_err    result, echoed tag, watchdog/illegal-op error
//     malu_rs1-3                 registered operands to the ALU
//     malu_valid                 high throughout RUN
//     malu_flush                 single-cycle ALU reset pulse
//     malu_uop_*                 one-hot uop lines (only in RUN)
//     malu_pw_*                  registered pack width
//     malu_result/malu_ready     ALU result and its valid strobe
import xc_malu_pkg::*;

module xc_malu_issue #(
  parameter int unsigned TIMEOUT = 128,
  parameter int unsigned CW      = 8
) (
  input  logic        clock,
  input  logic        resetn,

  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic        req_hi,
  input  logic [4:0]  req_pw,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_rs3,
  input  logic [4:0]  req_rd,

  input  logic        cancel,

  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err,

  output logic [31:0] malu_rs1,
  output logic [31:0] malu_rs2,
  output logic [31:0] malu_rs3,
  output logic        malu_valid,
  output logic        malu_flush,
  output logic        malu_uop_div,
  output logic        malu_uop_divu,
  output logic        malu_uop_rem,
  output logic        malu_uop_remu,
  output logic        malu_uop_mul,
  output logic        malu_uop_mulu,
  output logic        malu_uop_mulsu,
  output logic        malu_uop_clmul,
  output logic        malu_uop_pmul,
  output logic        malu_uop_pclmul,
  output logic        malu_uop_madd,
  output logic        malu_uop_msub,
  output logic        malu_uop_macc,
  output logic        malu_uop_mmul,
  output logic        malu_pw_2,
  output logic        malu_pw_4,
  output logic        malu_pw_8,
  output logic        malu_pw_16,
  output logic        malu_pw_32,
  input  logic [63:0] malu_result,
  input  logic        malu_ready
);

  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  state_t        state_q;
  logic [3:0]    op_q;
  logic          hi_q;
  logic [4:0]    pw_q;
  logic [CW-1:0] wd_q;

  logic [NUM_UOPS-1:0] dec_uop;
  logic [NUM_UOPS-1:0] uop_run;
  logic                dec_long;
  logic                in_run;
  logic                accept;
  logic                req_legal;
  logic                expire;
  logic [63:0]         sel_data;

  xc_malu_issue_dec u_dec (
    .op      (op_q),
    .uop     (dec_uop),
    .is_long (dec_long)
  );

  assign in_run     = (state_q == ST_RUN);
  assign req_ready  = (state_q == ST_IDLE) && !cancel;
  assign accept     = req_valid && req_ready;
  assign req_legal  = (req_op <= OP_MMUL);
  assign expire     = (wd_q == WD_LAST);

  assign rsp_valid  = (state_q == ST_RESP);
  assign malu_valid = in_run;
  // Every exit from RUN resets the ALU on that same edge; malu_ready wins over
  // expiry because both are handled identically here and only the data differs.
  assign malu_flush = in_run && (cancel || malu_ready || expire);

  // Uops are only presented while the ALU is running; the op register itself
  // still holds the last request after the run ends.
  assign uop_run = dec_uop & {NUM_UOPS{in_run}};

  assign malu_uop_div    = uop_run[OP_DIV];
  assign malu_uop_divu   = uop_run[OP_DIVU];
  assign malu_uop_rem    = uop_run[OP_REM];
  assign malu_uop_remu   = uop_run[OP_REMU];
  assign malu_uop_mul    = uop_run[OP_MUL];
  assign malu_uop_mulu   = uop_run[OP_MULU];
  assign malu_uop_mulsu  = uop_run[OP_MULSU];
  assign malu_uop_clmul  = uop_run[OP_CLMUL];
  assign malu_uop_pmul   = uop_run[OP_PMUL];
  assign malu_uop_pclmul = uop_run[OP_PCLMUL];
  assign malu_uop_madd   = uop_run[OP_MADD];
  assign malu_uop_msub   = uop_run[OP_MSUB];
  assign malu_uop_macc   = uop_run[OP_MACC];
  assign malu_uop_mmul   = uop_run[OP_MMUL];

  assign malu_pw_2  = pw_q[4];
  assign malu_pw_4  = pw_q[3];
  assign malu_pw_8  = pw_q[2];
  assign malu_pw_16 = pw_q[1];
  assign malu_pw_32 = pw_q[0];

  assign sel_data = dec_long ? malu_result
                             : {32'h0, hi_q ? malu_result[63:32] : malu_result[31:0]};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      hi_q     <= 1'b0;
      pw_q     <= '0;
      wd_q     <= '0;
      malu_rs1 <= '0;
      malu_rs2 <= '0;
      malu_rs3 <= '0;
      rsp_data <= '0;
      rsp_rd   <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q     <= req_op;
            hi_q     <= req_hi;
            pw_q     <= req_pw;
            wd_q     <= '0;
            malu_rs1 <= req_rs1;
            malu_rs2 <= req_rs2;
            malu_rs3 <= req_rs3;
            rsp_rd   <= req_rd;
            if (req_legal) begin
              state_q <= ST_RUN;
            end else begin
              // Illegal op never reaches the ALU: answer with an error at once.
              rsp_data <= '0;
              rsp_err  <= 1'b1;
              state_q  <= ST_RESP;
            end
          end
        end
        ST_RUN: begin
          if (cancel) begin
            state_q <= ST_IDLE;
          end else if (malu_ready) begin
            rsp_data <= sel_data;
            rsp_err  <= 1'b0;
            state_q  <= ST_RESP;
          end else if (expire) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            state_q  <= ST_RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (cancel || rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xc_malu_issue.sv
// tb_xc_malu_issue
//   Directed bench for xc_malu_issue with a behavioural ALU stub of programmable
//   latency. Table of requests with hand-computed results, plus sequences for
//   response stall, cancel in each state, and watchdog expiry.
import xc_malu_pkg::*;

module tb_xc_malu_issue;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic        req_hi = 1'b0;
  logic [4:0]  req_pw = '0;
  logic [31:0] req_rs1 = '0, req_rs2 = '0, req_rs3 = '0;
  logic [4:0]  req_rd = '0;
  logic        cancel = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err;
  logic [31:0] malu_rs1, malu_rs2, malu_rs3;
  logic        malu_valid, malu_flush;
  logic        u_div, u_divu, u_rem, u_remu, u_mul, u_mulu, u_mulsu;
  logic        u_clmul, u_pmul, u_pclmul, u_madd, u_msub, u_macc, u_mmul;
  logic        pw_2, pw_4, pw_8, pw_16, pw_32;
  logic [63:0] malu_result;
  logic        malu_ready;

  always #5 clock = ~clock;

  xc_malu_issue #(.TIMEOUT(16), .CW(8)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_hi(req_hi),
    .req_pw(req_pw), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
    .req_rd(req_rd), .cancel(cancel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
    .malu_valid(malu_valid), .malu_flush(malu_flush),
    .malu_uop_div(u_div), .malu_uop_divu(u_divu), .malu_uop_rem(u_rem),
    .malu_uop_remu(u_remu), .malu_uop_mul(u_mul), .malu_uop_mulu(u_mulu),
    .malu_uop_mulsu(u_mulsu), .malu_uop_clmul(u_clmul), .malu_uop_pmul(u_pmul),
    .malu_uop_pclmul(u_pclmul), .malu_uop_madd(u_madd), .malu_uop_msub(u_msub),
    .malu_uop_macc(u_macc), .malu_uop_mmul(u_mmul),
    .malu_pw_2(pw_2), .malu_pw_4(pw_4), .malu_pw_8(pw_8), .malu_pw_16(pw_16),
    .malu_pw_32(pw_32),
    .malu_result(malu_result), .malu_ready(malu_ready)
  );

  logic [13:0] uop_vec;
  logic [4:0]  pw_vec;
  assign uop_vec = {u_mmul, u_macc, u_msub, u_madd, u_pclmul, u_pmul, u_clmul,
                    u_mulsu, u_mulu, u_mul, u_remu, u_rem, u_divu, u_div};
  assign pw_vec  = {pw_2, pw_4, pw_8, pw_16, pw_32};

  // ---------------- ALU stub ----------------
  logic [7:0] alu_cnt;
  logic [7:0] alu_lat = 8'd0;
  logic       alu_never = 1'b0;

  always @(posedge clock) begin
    if (!malu_valid || malu_flush) alu_cnt <= 8'd0;
    else                           alu_cnt <= alu_cnt + 8'd1;
  end

  assign malu_ready = malu_valid && !alu_never && (alu_cnt == alu_lat);

  logic signed [63:0] sa, sb;
  logic signed [31:0] sq;
  always_comb begin
    sa = $signed(malu_rs1);
    sb = $signed(malu_rs2);
    sq = '0;
    malu_result = {malu_rs1 ^ malu_rs3, malu_rs2 + malu_rs3};
    if (u_div)   begin sq = $signed(malu_rs1) / $signed(malu_rs2); malu_result = {32'h0, sq}; end
    if (u_divu)  malu_result = {32'h0, malu_rs1 / malu_rs2};
    if (u_rem)   begin sq = $signed(malu_rs1) % $signed(malu_rs2); malu_result = {32'h0, sq}; end
    if (u_remu)  malu_result = {32'h0, malu_rs1 % malu_rs2};
    if (u_mul)   malu_result = sa * sb;
    if (u_mulu)  malu_result = {32'h0, malu_rs1} * {32'h0, malu_rs2};
    if (u_mulsu) malu_result = sa * $signed({32'h0, malu_rs2});
    if (u_madd)  malu_result = {32'h0, malu_rs1} * {32'h0, malu_rs2} + {32'h0, malu_rs3};
  end

  // ---------------- counters and checks ----------------
  int nvec = 0;
  int nfail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int          flush_cnt = 0;
  int          run_cycles = 0;
  logic [13:0] seen_uop = '0;
  logic [4:0]  seen_pw = '0;
  logic [31:0] seen_rs1 = '0;
  logic        prev_flush = 1'b0;

  always @(negedge clock) begin
    if (resetn) begin
      if (malu_flush) begin
        flush_cnt++;
        check("flush_not_consecutive", 64'(prev_flush), 64'(1'b0));
      end
      prev_flush = malu_flush;
      if (malu_valid) begin
        if (run_cycles == 0) begin
          seen_uop = uop_vec;
          seen_pw  = pw_vec;
          seen_rs1 = malu_rs1;
        end
        run_cycles++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        hi;
    logic [4:0]  pw;
    logic [31:0] rs1, rs2, rs3;
    logic [4:0]  rd;
    logic [7:0]  lat;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  // Present a request and complete the accept edge; waits = cycles req_ready was low.
  task automatic issue(input vec_t v, output int waits);
    alu_lat   = v.lat;
    req_op    = v.op;  req_hi  = v.hi;  req_pw  = v.pw;
    req_rs1   = v.rs1; req_rs2 = v.rs2; req_rs3 = v.rs3; req_rd = v.rd;
    req_valid = 1'b1;
    waits = 0;
    while (!req_ready && waits < 20) begin
      tick();
      waits++;
    end
    flush_cnt  = 0;
    run_cycles = 0;
    seen_uop   = '0;
    seen_pw    = '0;
    seen_rs1   = '0;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    check({name, "_rsp_arrives"}, 64'(rsp_valid), 64'(1'b1));
  endtask

  vec_t vecs[13];
  vec_t v;
  int   w;
  bit   legal;

  initial begin
    vecs[0]  = '{OP_DIVU,  1'b0, 5'b00001, 32'd100,      32'd7,        32'd0,        5'd5,  8'd3,  64'd14,                  1'b0};
    vecs[1]  = '{OP_REM,   1'b0, 5'b00010, 32'hFFFFFFF9, 32'd3,        32'd0,        5'd9,  8'd2,  64'h0000_0000_FFFF_FFFF, 1'b0};
    vecs[2]  = '{OP_MULU,  1'b1, 5'b00100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        5'd17, 8'd4,  64'h0000_0000_FFFF_FFFE, 1'b0};
    vecs[3]  = '{OP_MADD,  1'b0, 5'b01000, 32'hFFFFFFFF, 32'd2,        32'd1,        5'd31, 8'd1,  64'h0000_0001_FFFF_FFFF, 1'b0};
    vecs[4]  = '{OP_MUL,   1'b0, 5'b10000, 32'hFFFFFFFE, 32'd3,        32'd0,        5'd1,  8'd0,  64'h0000_0000_FFFF_FFFA, 1'b0};
    vecs[5]  = '{OP_MUL,   1'b1, 5'b00001, 32'hFFFFFFFE, 32'd3,        32'd0,        5'd2,  8'd5,  64'h0000_0000_FFFF_FFFF, 1'b0};
    vecs[6]  = '{OP_DIV,   1'b0, 5'b00001, 32'hFFFFFFEC, 32'd6,        32'd0,        5'd3,  8'd2,  64'h0000_0000_FFFF_FFFD, 1'b0};
    vecs[7]  = '{OP_CLMUL, 1'b0, 5'b00001, 32'h12345678, 32'h0F0F0F0F, 32'hFFFF0000, 5'd4,  8'd1,  64'h0000_0000_0F0E_0F0F, 1'b0};
    vecs[8]  = '{OP_CLMUL, 1'b1, 5'b00001, 32'h12345678, 32'h0F0F0F0F, 32'hFFFF0000, 5'd6,  8'd1,  64'h0000_0000_EDCB_5678, 1'b0};
    vecs[9]  = '{OP_MMUL,  1'b0, 5'b00001, 32'd1,        32'd2,        32'd3,        5'd7,  8'd2,  64'h0000_0002_0000_0005, 1'b0};
    vecs[10] = '{OP_MACC,  1'b1, 5'b00001, 32'hA,        32'hB,        32'h1,        5'd8,  8'd3,  64'h0000_000B_0000_000C, 1'b0};
    vecs[11] = '{4'd15,    1'b0, 5'b00001, 32'd1,        32'd1,        32'd1,        5'd10, 8'd0,  64'd0,                   1'b1};
    // malu_ready arrives on the same cycle the watchdog would expire
    vecs[12] = '{OP_DIVU,  1'b0, 5'b00001, 32'd50,       32'd5,        32'd0,        5'd11, 8'd15, 64'd10,                  1'b0};

    // ---- reset state ----
    #12;
    check("rst_req_ready",  64'(req_ready),  64'(1'b1));
    check("rst_rsp_valid",  64'(rsp_valid),  64'(1'b0));
    check("rst_rsp_data",   rsp_data,        64'd0);
    check("rst_rsp_rd",     64'(rsp_rd),     64'd0);
    check("rst_rsp_err",    64'(rsp_err),    64'(1'b0));
    check("rst_malu_valid", 64'(malu_valid), 64'(1'b0));
    check("rst_malu_flush", 64'(malu_flush), 64'(1'b0));
    check("rst_malu_rs1",   64'(malu_rs1),   64'd0);
    check("rst_uops",       64'(uop_vec),    64'd0);
    tick();
    resetn = 1'b1;
    tick();

    // ---- table ----
    for (int i = 0; i < 13; i++) begin
      v = vecs[i];
      legal = (v.op <= OP_MMUL);
      issue(v, w);
      check($sformatf("v%0d_accept_wait", i), 64'(w), 64'd0);
      wait_rsp($sformatf("v%0d", i));
      check($sformatf("v%0d_data", i),   rsp_data,          v.exp_data);
      check($sformatf("v%0d_rd", i),     64'(rsp_rd),       64'(v.rd));
      check($sformatf("v%0d_err", i),    64'(rsp_err),      64'(v.exp_err));
      check($sformatf("v%0d_flushes", i), 64'(flush_cnt),   legal ? 64'd1 : 64'd0);
      check($sformatf("v%0d_run_cycles", i), 64'(run_cycles), legal ? 64'(v.lat) + 64'd1 : 64'd0);
      check($sformatf("v%0d_uop", i),    64'(seen_uop),     legal ? (64'd1 << v.op) : 64'd0);
      check($sformatf("v%0d_pw", i),     64'(seen_pw),      legal ? 64'(v.pw) : 64'd0);
      check($sformatf("v%0d_rs1", i),    64'(seen_rs1),     legal ? 64'(v.rs1) : 64'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check($sformatf("v%0d_rsp_drops", i), 64'(rsp_valid), 64'(1'b0));
    end

    // ---- response stall: held stable, nothing accepted ----
    v = '{OP_DIVU, 1'b0, 5'b00001, 32'd100, 32'd7, 32'd0, 5'd21, 8'd2, 64'd14, 1'b0};
    issue(v, w);
    wait_rsp("stall");
    req_op = OP_MUL; req_rd = 5'd22; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("stall_valid",     64'(rsp_valid),  64'(1'b1));
      check("stall_data",      rsp_data,        64'd14);
      check("stall_rd",        64'(rsp_rd),     64'd21);
      check("stall_err",       64'(rsp_err),    64'(1'b0));
      check("stall_req_ready", 64'(req_ready),  64'(1'b0));
      check("stall_no_run",    64'(malu_valid), 64'(1'b0));
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("stall_release", 64'(req_ready), 64'(1'b1));

    // ---- cancel three cycles into a divide ----
    v = '{OP_DIV, 1'b0, 5'b00001, 32'd100, 32'd7, 32'd0, 5'd12, 8'd50, 64'd0, 1'b0};
    issue(v, w);
    tick();
    tick();
    cancel = 1'b1;
    #1;
    check("cancel_run_flush",     64'(malu_flush), 64'(1'b1));
    check("cancel_run_req_ready", 64'(req_ready),  64'(1'b0));
    tick();
    cancel = 1'b0;
    #1;
    check("cancel_run_idle",      64'(req_ready),  64'(1'b1));
    check("cancel_run_no_valid",  64'(malu_valid), 64'(1'b0));
    check("cancel_run_no_rsp",    64'(rsp_valid),  64'(1'b0));
    check("cancel_run_flushes",   64'(flush_cnt),  64'd1);
    v = '{OP_DIVU, 1'b0, 5'b00001, 32'd100, 32'd7, 32'd0, 5'd13, 8'd1, 64'd14, 1'b0};
    issue(v, w);
    check("after_cancel_accept_wait", 64'(w), 64'd0);
    wait_rsp("after_cancel");
    check("after_cancel_data", rsp_data,    64'd14);
    check("after_cancel_rd",   64'(rsp_rd), 64'd13);

    // ---- cancel in RESP beats rsp_ready ----
    cancel = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("cancel_resp_no_flush", 64'(malu_flush), 64'(1'b0));
    tick();
    cancel = 1'b0;
    rsp_ready = 1'b0;
    #1;
    check("cancel_resp_drop", 64'(rsp_valid), 64'(1'b0));
    check("cancel_resp_idle", 64'(req_ready), 64'(1'b1));

    // ---- cancel in IDLE blocks acceptance ----
    req_valid = 1'b1;
    req_op = OP_DIVU;
    cancel = 1'b1;
    #1;
    check("cancel_idle_block", 64'(req_ready), 64'(1'b0));
    tick();
    req_valid = 1'b0;
    cancel = 1'b0;
    #1;
    check("cancel_idle_not_taken", 64'(malu_valid | rsp_valid), 64'(1'b0));

    // ---- watchdog expiry with an ALU that never answers ----
    alu_never = 1'b1;
    v = '{OP_DIV, 1'b0, 5'b00001, 32'd9, 32'd3, 32'd0, 5'd14, 8'd0, 64'd0, 1'b1};
    issue(v, w);
    wait_rsp("timeout");
    check("timeout_err",        64'(rsp_err),    64'(1'b1));
    check("timeout_data",       rsp_data,        64'd0);
    check("timeout_rd",         64'(rsp_rd),     64'd14);
    check("timeout_run_cycles", 64'(run_cycles), 64'd16);
    check("timeout_flushes",    64'(flush_cnt),  64'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    alu_never = 1'b0;
    check("timeout_done", 64'(req_ready), 64'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
